transport_block_framer: RTL

- Parametrised successor of the fixed 480-byte transport block shaper in the Tx chain.
- Sits between the byte/word source and the modulator-side consumer; forwards upstream words into fixed-length transport blocks.
- When the source stalls mid-block for WAIT_CYCLES, or on a flush request, it closes the block with pad words (constant or PRBS).
- Adds block framing flags, configurable idle-boundary behaviour and a completed-block counter.

---
 rtl/tbf_pkg.sv | 20 ++
 rtl/transport_block_framer_if.sv | 30 +++
 rtl/tbf_pad_gen.sv | 35 +++
 rtl/transport_block_framer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tbf_pkg.sv
// Shared types and constants for the transport block framer.
// Holds the framer state encoding, the pad LFSR seed/taps and a width helper.
// Imported by the pad generator and the framer top.
package tbf_pkg;

    typedef enum logic {
        DATA = 1'b0,
        PAD  = 1'b1
    } state_t;

    // Pad LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form.
    // In that form the feedback bit is the XOR of state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/transport_block_framer_if.sv
// Word stream bundle between upstream source, framer and downstream consumer.
// slave: the framer's view (consumes ival/idata/ireq/iflush, drives the rest).
// master: the environment's view (drives the inputs, observes framed output).
interface transport_block_framer_if #(
    parameter int DATA_W   = 8,
    parameter int BLKCNT_W = 16
);
    logic                ival;
    logic [DATA_W-1:0]   idata;
    logic                ireq;
    logic                iflush;
    logic                oreq;
    logic                oval;
    logic [DATA_W-1:0]   odata;
    logic                osob;
    logic                oeob;
    logic                opad;
    logic                oblk_done;
    logic [BLKCNT_W-1:0] oblk_cnt;

    modport slave (
        input  ival, idata, ireq, iflush,
        output oreq, oval, odata, osob, oeob, opad, oblk_done, oblk_cnt
    );

    modport master (
        output ival, idata, ireq, iflush,
        input  oreq, oval, odata, osob, oeob, opad, oblk_done, oblk_cnt
    );
endinterface

// File: rtl/tbf_pad_gen.sv
// Pad word generator: constant PAD_VALUE or low DATA_W bits of a 16-bit LFSR.
// Latency: pad word is combinational from the LFSR register; step advances on the next edge.
// Backpressure: LFSR holds unless i_step (one transferred pad word) is high.
// Ports: clk/rst_n; i_load reseeds, i_step advances one step, o_pad_dat is the current pad word.
module tbf_pad_gen
    import tbf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PAD_MODE  = 0,
    parameter int PAD_VALUE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_pad_dat
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
        end
    end

    // The LFSR runs in both modes so the constant-pad build has no dangling logic;
    // synthesis strips it when PAD_MODE selects the constant.
    assign o_pad_dat = (PAD_MODE == 1) ? r_lfsr[DATA_W-1:0] : DATA_W'(PAD_VALUE);

endmodule

// File: rtl/transport_block_framer.sv
// Transport block framer: forwards upstream words into BLOCK_LEN-word blocks, padding on stall/flush.
// Latency: zero; all outputs except oblk_done/oblk_cnt are combinational from state and inputs.
// Backpressure: oreq follows ireq in DATA and is 0 in PAD; nothing advances while ireq is low.
// Ports: clk, rst_n (async, active low); bus (slave modport) carries the upstream word
// stream (ival/idata/oreq), downstream handshake (oval/odata/ireq), flush request,
// framing flags (osob/oeob/opad) and block completion (oblk_done pulse, oblk_cnt).
module transport_block_framer
    import tbf_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BLOCK_LEN   = 480,
    parameter int WAIT_CYCLES = 5,
    parameter int PAD_MODE    = 0,
    parameter int PAD_VALUE   = 0,
    parameter int IDLE_PAD    = 0,
    parameter int BLKCNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    transport_block_framer_if.slave bus
);

    localparam int CW = cnt_w(BLOCK_LEN);
    // +1 keeps the wait counter at least one bit wide when WAIT_CYCLES is 1.
    localparam int WW = cnt_w(WAIT_CYCLES + 1);

    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_LEN - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt_word;
    logic [WW-1:0]       r_cnt_wait;
    logic                r_blk_done;
    logic [BLKCNT_W-1:0] r_blk_cnt;

    state_t              w_nxt_state;
    logic [WW-1:0]       w_nxt_wait;
    logic                w_oval_raw;
    logic                w_oreq_raw;
    logic [DATA_W-1:0]   w_odat_raw;
    logic                w_pad_flag;
    logic                w_pad_load;
    logic                w_pad_step;
    logic [DATA_W-1:0]   w_pad_dat;
    logic                w_xfer;
    logic                w_last;
    logic                w_cnt_nz;

    assign w_last   = (r_cnt_word == LAST_WORD);
    assign w_cnt_nz = (r_cnt_word != '0);
    // In PAD a word is always offered, so a transfer is just a downstream request.
    assign w_xfer   = bus.ireq & ((r_state == PAD) | bus.ival);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wait  = r_cnt_wait;
        w_oval_raw  = 1'b0;
        w_oreq_raw  = 1'b0;
        w_odat_raw  = '0;
        w_pad_flag  = 1'b0;
        w_pad_load  = 1'b0;
        w_pad_step  = 1'b0;
        case (r_state)
            DATA: begin
                w_oreq_raw = bus.ireq;
                w_oval_raw = bus.ival;
                w_odat_raw = bus.idata;
                // Flush wins over the starvation timeout; an empty block is never flushed.
                if (bus.iflush && w_cnt_nz) begin
                    w_nxt_state = PAD;
                    w_nxt_wait  = '0;
                end else if (bus.ireq && !bus.ival) begin
                    if (r_cnt_wait == WAIT_LAST) begin
                        w_nxt_wait = '0;
                        if (w_cnt_nz || (IDLE_PAD != 0)) begin
                            w_nxt_state = PAD;
                        end
                    end else begin
                        w_nxt_wait = r_cnt_wait + 1'b1;
                    end
                end else if (w_xfer) begin
                    w_nxt_wait = '0;
                end
                // Every pad run starts the pattern from the seed.
                w_pad_load = (w_nxt_state == PAD);
            end
            PAD: begin
                w_oval_raw = 1'b1;
                w_odat_raw = w_pad_dat;
                w_pad_flag = 1'b1;
                w_pad_step = bus.ireq;
                if (bus.ireq && w_last) begin
                    w_nxt_state = DATA;
                end
            end
            default: begin
                w_nxt_state = DATA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= DATA;
            r_cnt_word <= '0;
            r_cnt_wait <= '0;
            r_blk_done <= 1'b0;
            r_blk_cnt  <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt_wait <= w_nxt_wait;
            r_blk_done <= w_xfer & w_last;
            if (w_xfer) begin
                r_cnt_word <= w_last ? '0 : r_cnt_word + 1'b1;
            end
            if (w_xfer && w_last) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    tbf_pad_gen #(
        .DATA_W   (DATA_W),
        .PAD_MODE (PAD_MODE),
        .PAD_VALUE(PAD_VALUE)
    ) u_pad_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_pad_load),
        .i_step   (w_pad_step),
        .o_pad_dat(w_pad_dat)
    );

    // Combinational outputs are gated by rst_n so they drop the instant reset asserts.
    assign bus.oreq      = rst_n & w_oreq_raw;
    assign bus.oval      = rst_n & w_oval_raw;
    assign bus.odata     = rst_n ? w_odat_raw : '0;
    assign bus.opad      = rst_n & w_pad_flag;
    assign bus.osob      = bus.oval & (r_cnt_word == '0);
    assign bus.oeob      = bus.oval & w_last;
    assign bus.oblk_done = r_blk_done;
    assign bus.oblk_cnt  = r_blk_cnt;

endmodule
